// File: rtl/hmmm_core_mc.sv
// Multicycle HMMM-style core with parametrised widths, separate instruction/data
// ports with req/ready wait states, and two-phase (ph2 master / ph1 slave) state.
module hmmm_core_mc #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                  ph1,
   input  logic                  ph2,
   input  logic                  reset,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [15:0]           imem_rdata,
   input  logic                  imem_ready,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [ADDR_WIDTH-1:0] dmem_addr,
   output logic [DATA_WIDTH-1:0] dmem_wdata,
   input  logic [DATA_WIDTH-1:0] dmem_rdata,
   input  logic                  dmem_ready,
   output logic                  retire,
   output logic                  halted,
   output logic                  illegal
);

   typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

   localparam logic [3:0] OP_HALT   = 4'h0;
   localparam logic [3:0] OP_SETN   = 4'h1;
   localparam logic [3:0] OP_ADDN   = 4'h2;
   localparam logic [3:0] OP_ADD    = 4'h3;
   localparam logic [3:0] OP_SUB    = 4'h4;
   localparam logic [3:0] OP_LOADR  = 4'h5;
   localparam logic [3:0] OP_STORER = 4'h6;
   localparam logic [3:0] OP_JUMPN  = 4'h7;
   localparam logic [3:0] OP_JUMPR  = 4'h8;
   localparam logic [3:0] OP_JEQZN  = 4'h9;
   localparam logic [3:0] OP_JNEZN  = 4'hA;
   localparam logic [3:0] OP_JGTZN  = 4'hB;
   localparam logic [3:0] OP_JLTZN  = 4'hC;
   localparam logic [3:0] OP_CALLN  = 4'hD;
   localparam logic [3:0] OP_NOP    = 4'hE;

   state_t                  state_s, state_m, state_n;
   logic [ADDR_WIDTH-1:0]   pc_s, pc_m, pc_n, pc_inc;
   logic [15:0]             instr_s, instr_m, instr_n;
   logic                    ill_s, ill_m, ill_n;
   logic [DATA_WIDTH-1:0]   regs_s [8];
   logic [DATA_WIDTH-1:0]   regs_m [8];

   logic                    wr_en;
   logic [2:0]              wr_idx;
   logic [DATA_WIDTH-1:0]   wr_data;
   logic                    retire_c;
   logic [3:0]              op;
   logic [2:0]              rd_f, ra_f, rb_f;
   logic [7:0]              imm;
   logic [DATA_WIDTH-1:0]   rd_val, ra_val, rb_val;
   logic                    rd_zero, rd_neg, take;
   logic                    mem_act;
   logic                    unused_op_bit;

   function automatic logic [DATA_WIDTH-1:0] sext_imm(input logic [7:0] v);
      return DATA_WIDTH'($signed(v));
   endfunction

   assign op            = instr_s[15:12];
   assign rd_f          = instr_s[10:8];
   assign ra_f          = instr_s[7:5];
   assign rb_f          = instr_s[4:2];
   assign imm           = instr_s[7:0];
   assign unused_op_bit = instr_s[11];

   // r0 is hard-wired to zero on the read side
   assign rd_val = (rd_f == 3'd0) ? '0 : regs_s[rd_f];
   assign ra_val = (ra_f == 3'd0) ? '0 : regs_s[ra_f];
   assign rb_val = (rb_f == 3'd0) ? '0 : regs_s[rb_f];
   assign pc_inc = pc_s + ADDR_WIDTH'(1);

   assign rd_zero = (rd_val == '0);
   assign rd_neg  = rd_val[DATA_WIDTH-1];

   always_comb begin
      take = 1'b0;
      case (op)
         OP_JEQZN: take = rd_zero;
         OP_JNEZN: take = !rd_zero;
         OP_JGTZN: take = !rd_zero && !rd_neg;
         OP_JLTZN: take = rd_neg;
         default:  take = 1'b0;
      endcase
   end

   always_comb begin
      state_n  = state_s;
      pc_n     = pc_s;
      instr_n  = instr_s;
      ill_n    = ill_s;
      wr_en    = 1'b0;
      wr_idx   = rd_f;
      wr_data  = '0;
      retire_c = 1'b0;
      case (state_s)
         FETCH: begin
            if (imem_ready) begin
               instr_n = imem_rdata;
               state_n = EXEC;
            end
         end
         EXEC: begin
            state_n  = FETCH;
            retire_c = 1'b1;
            pc_n     = pc_inc;
            case (op)
               OP_HALT: begin
                  state_n  = HALT;
                  retire_c = 1'b0;
                  pc_n     = pc_s;
               end
               OP_SETN: begin
                  wr_en   = 1'b1;
                  wr_data = sext_imm(imm);
               end
               OP_ADDN: begin
                  wr_en   = 1'b1;
                  wr_data = rd_val + sext_imm(imm);
               end
               OP_ADD: begin
                  wr_en   = 1'b1;
                  wr_data = ra_val + rb_val;
               end
               OP_SUB: begin
                  wr_en   = 1'b1;
                  wr_data = ra_val - rb_val;
               end
               OP_LOADR, OP_STORER: begin
                  state_n  = MEM;
                  retire_c = 1'b0;
                  pc_n     = pc_s;
               end
               OP_JUMPN: pc_n = ADDR_WIDTH'(imm);
               OP_JUMPR: pc_n = ADDR_WIDTH'(ra_val);
               OP_JEQZN, OP_JNEZN, OP_JGTZN, OP_JLTZN: begin
                  if (take) pc_n = ADDR_WIDTH'(imm);
               end
               OP_CALLN: begin
                  wr_en   = 1'b1;
                  wr_data = DATA_WIDTH'(pc_inc);
                  pc_n    = ADDR_WIDTH'(imm);
               end
               OP_NOP: pc_n = pc_inc;
               default: begin
                  state_n  = HALT;
                  ill_n    = 1'b1;
                  retire_c = 1'b0;
                  pc_n     = pc_s;
               end
            endcase
         end
         MEM: begin
            if (dmem_ready) begin
               wr_en    = (op == OP_LOADR);
               wr_data  = dmem_rdata;
               pc_n     = pc_inc;
               retire_c = 1'b1;
               state_n  = FETCH;
            end
         end
         default: ;
      endcase
   end

   // master stage: captures next state (or reset values) while ph2 is active
   always_ff @(posedge ph2) begin
      if (reset) begin
         state_m <= FETCH;
         pc_m    <= RESET_PC;
         instr_m <= '0;
         ill_m   <= 1'b0;
         for (int i = 0; i < 8; i++) regs_m[i] <= '0;
      end else begin
         state_m <= state_n;
         pc_m    <= pc_n;
         instr_m <= instr_n;
         ill_m   <= ill_n;
         for (int i = 0; i < 8; i++)
            regs_m[i] <= (wr_en && (i != 0) && (wr_idx == 3'(i))) ? wr_data : regs_s[i];
      end
   end

   // slave stage: publishes master contents on ph1
   always_ff @(posedge ph1) begin
      state_s <= state_m;
      pc_s    <= pc_m;
      instr_s <= instr_m;
      ill_s   <= ill_m;
      for (int i = 0; i < 8; i++) regs_s[i] <= regs_m[i];
   end

   // requests are gated by reset so an outstanding access is dropped immediately
   assign mem_act    = (state_s == MEM) && !reset;
   assign imem_req   = (state_s == FETCH) && !reset;
   assign imem_addr  = pc_s;
   assign dmem_req   = mem_act;
   assign dmem_we    = mem_act && (op == OP_STORER);
   assign dmem_addr  = mem_act ? ADDR_WIDTH'(ra_val) : '0;
   assign dmem_wdata = mem_act ? rd_val : '0;
   assign retire     = retire_c && !reset;
   assign halted     = (state_s == HALT);
   assign illegal    = ill_s;

endmodule

// File: tb/tb_hmmm_core_mc.sv
// Directed bench for hmmm_core_mc: 8/8 core with memory models plus a 16/12
// instance for the wide-width reset-during-MEM case.
module tb_hmmm_core_mc;

   logic ph1 = 1'b0, ph2 = 1'b0;
   logic reset = 1'b1, reset_b = 1'b1;

   logic        imem_req, imem_ready = 1'b0, dmem_req, dmem_we, dmem_ready = 1'b0;
   logic [7:0]  imem_addr, dmem_addr, dmem_wdata, dmem_rdata;
   logic [15:0] imem_rdata;
   logic        retire, halted, illegal;

   logic        b_imem_req, b_dmem_req, b_dmem_we, b_retire, b_halted, b_illegal;
   logic        b_iready = 1'b1, b_dready = 1'b0;
   logic [11:0] b_imem_addr, b_dmem_addr;
   logic [15:0] b_imem_rdata, b_dmem_wdata, b_dmem_rdata;

   logic [15:0] imem [256];
   logic [7:0]  dmem [256];

   int n_checks = 0, n_errors = 0;
   int n_retire, n_dreq, n_dacc, n_ireq, n_unstable, cyc;
   int iwait = 0, dwait = 0, icnt = 0, dcnt = 0;
   logic force_dready = 1'b0, i_pend = 1'b0, d_pend = 1'b0;
   logic [7:0] i_addr_prev, d_addr_prev, d_wdata_prev;
   logic d_we_prev;

   hmmm_core_mc #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .RESET_PC(8'h00)) dut_a (
      .ph1(ph1), .ph2(ph2), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
      .retire(retire), .halted(halted), .illegal(illegal)
   );

   hmmm_core_mc #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .RESET_PC(12'h0A5)) dut_b (
      .ph1(ph1), .ph2(ph2), .reset(reset_b),
      .imem_req(b_imem_req), .imem_addr(b_imem_addr), .imem_rdata(b_imem_rdata), .imem_ready(b_iready),
      .dmem_req(b_dmem_req), .dmem_we(b_dmem_we), .dmem_addr(b_dmem_addr), .dmem_wdata(b_dmem_wdata),
      .dmem_rdata(b_dmem_rdata), .dmem_ready(b_dready),
      .retire(b_retire), .halted(b_halted), .illegal(b_illegal)
   );

   function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rd, input logic [7:0] imm);
      return {op, 1'b0, rd, imm};
   endfunction

   function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                         input logic [2:0] ra, input logic [2:0] rb);
      return {op, 1'b0, rd, ra, rb, 2'b00};
   endfunction

   function automatic logic [15:0] b_prog(input logic [11:0] a);
      case (a)
         12'h0A5: return enc_i(4'h1, 3'd1, 8'h80);
         12'h0A6: return enc_r(4'h5, 3'd3, 3'd1, 3'd0);
         default: return 16'h0000;
      endcase
   endfunction

   assign imem_rdata   = imem[imem_addr];
   assign dmem_rdata   = dmem[dmem_addr];
   assign b_imem_rdata = b_prog(b_imem_addr);
   assign b_dmem_rdata = 16'hBEEF;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // one ph2/ph1 cycle; memory models respond after their programmed wait count
   task automatic step();
      imem_ready = imem_req && (icnt >= iwait);
      dmem_ready = force_dready || (dmem_req && (dcnt >= dwait));
      #1;
      if (retire) n_retire++;
      if (imem_req) begin
         n_ireq++;
         if (i_pend && imem_addr != i_addr_prev) n_unstable++;
         i_addr_prev = imem_addr;
      end
      if (dmem_req) begin
         n_dreq++;
         if (d_pend && (dmem_addr != d_addr_prev || dmem_wdata != d_wdata_prev || dmem_we != d_we_prev))
            n_unstable++;
         d_addr_prev = dmem_addr; d_wdata_prev = dmem_wdata; d_we_prev = dmem_we;
         if (dmem_ready) begin
            n_dacc++;
            if (dmem_we) dmem[dmem_addr] = dmem_wdata;
         end
      end
      i_pend = imem_req && !imem_ready;
      d_pend = dmem_req && !dmem_ready;
      icnt = i_pend ? icnt + 1 : 0;
      dcnt = d_pend ? dcnt + 1 : 0;
      #4 ph2 = 1'b1; #5 ph2 = 1'b0; #5 ph1 = 1'b1; #5 ph1 = 1'b0; #5;
      cyc++;
   endtask

   task automatic clear_counts();
      n_retire = 0; n_dreq = 0; n_dacc = 0; n_ireq = 0; n_unstable = 0; cyc = 0;
      icnt = 0; dcnt = 0; i_pend = 1'b0; d_pend = 1'b0;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) begin imem[i] = 16'h0000; dmem[i] = 8'h00; end
   endtask

   task automatic reset_dut();
      reset = 1'b1; force_dready = 1'b0;
      step(); step();
      reset = 1'b0;
      clear_counts();
      #1;
   endtask

   task automatic run_until_halt(input int budget, output int cycles);
      cycles = 0;
      while (!halted && cycles < budget) begin step(); cycles++; end
      check("halt_reached", 32'(halted), 32'd1);
   endtask

   int c;

   initial begin
      // 1: reset state and a short program
      clear_mem();
      imem[0] = enc_i(4'h1, 3'd1, 8'd5);
      imem[1] = enc_i(4'h2, 3'd1, 8'hFF);
      imem[2] = 16'h0000;
      clear_counts();
      step(); step();
      check("rst_imem_req", 32'(imem_req), 32'd0);
      check("rst_dmem_req", 32'(dmem_req), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_illegal", 32'(illegal), 32'd0);
      check("rst_imem_addr", 32'(imem_addr), 32'h00);
      reset = 1'b0; clear_counts(); #1;
      check("rel_imem_req", 32'(imem_req), 32'd1);
      run_until_halt(50, c);
      check("t1_cycles", 32'(c), 32'd6);
      check("t1_r1", 32'(dut_a.regs_s[1]), 32'h04);
      check("t1_retire", 32'(n_retire), 32'd2);
      check("t1_illegal", 32'(illegal), 32'd0);

      // 2: add/sub wrap and r0
      clear_mem();
      imem[0] = enc_i(4'h1, 3'd1, 8'h7F);
      imem[1] = enc_i(4'h1, 3'd2, 8'h81);
      imem[2] = enc_r(4'h3, 3'd3, 3'd1, 3'd2);
      imem[3] = enc_r(4'h4, 3'd4, 3'd1, 3'd2);
      imem[4] = enc_i(4'h1, 3'd0, 8'h55);
      imem[5] = enc_r(4'h3, 3'd5, 3'd0, 3'd0);
      reset_dut();
      run_until_halt(50, c);
      check("t2_r2", 32'(dut_a.regs_s[2]), 32'h81);
      check("t2_add", 32'(dut_a.regs_s[3]), 32'h00);
      check("t2_sub", 32'(dut_a.regs_s[4]), 32'hFE);
      check("t2_r0", 32'(dut_a.regs_s[5]), 32'h00);
      check("t2_retire", 32'(n_retire), 32'd6);

      // 3: store/load with three data wait states
      clear_mem();
      imem[0] = enc_i(4'h1, 3'd1, 8'h3C);
      imem[1] = enc_i(4'h1, 3'd2, 8'h40);
      imem[2] = enc_r(4'h6, 3'd1, 3'd2, 3'd0);
      imem[3] = enc_r(4'h5, 3'd3, 3'd2, 3'd0);
      imem[4] = enc_r(4'h5, 3'd0, 3'd2, 3'd0);
      dwait = 3;
      reset_dut();
      run_until_halt(100, c);
      check("t3_cycles", 32'(c), 32'd24);
      check("t3_mem", 32'(dmem[8'h40]), 32'h3C);
      check("t3_r3", 32'(dut_a.regs_s[3]), 32'h3C);
      check("t3_dreq_cycles", 32'(n_dreq), 32'd12);
      check("t3_accesses", 32'(n_dacc), 32'd3);
      check("t3_stable", 32'(n_unstable), 32'd0);
      check("t3_retire", 32'(n_retire), 32'd5);
      dwait = 0;

      // 4: branches, call, jumpr
      clear_mem();
      imem[8'h00] = enc_i(4'h1, 3'd1, 8'hFF);
      imem[8'h01] = enc_i(4'hC, 3'd1, 8'h05);
      imem[8'h02] = enc_i(4'h1, 3'd6, 8'h01);
      imem[8'h05] = enc_i(4'hB, 3'd1, 8'h02);
      imem[8'h06] = enc_i(4'h9, 3'd0, 8'h10);
      imem[8'h10] = enc_i(4'hD, 3'd5, 8'h20);
      imem[8'h20] = enc_i(4'hA, 3'd1, 8'h22);
      imem[8'h22] = enc_i(4'h1, 3'd7, 8'h30);
      imem[8'h23] = enc_r(4'h8, 3'd0, 3'd7, 3'd0);
      reset_dut();
      run_until_halt(100, c);
      check("t4_link", 32'(dut_a.regs_s[5]), 32'h11);
      check("t4_skipped", 32'(dut_a.regs_s[6]), 32'h00);
      check("t4_r7", 32'(dut_a.regs_s[7]), 32'h30);
      check("t4_final_pc", 32'(imem_addr), 32'h30);
      check("t4_retire", 32'(n_retire), 32'd8);

      // 5a: PC wrap with two fetch wait states
      clear_mem();
      imem[8'h00] = enc_i(4'h7, 3'd0, 8'hFF);
      imem[8'hFF] = enc_i(4'hE, 3'd0, 8'h00);
      iwait = 2;
      reset_dut();
      for (int i = 0; i < 8; i++) step();
      check("t5_wrap_addr", 32'(imem_addr), 32'h00);
      check("t5_wrap_retire", 32'(n_retire), 32'd2);
      check("t5_imem_stable", 32'(n_unstable), 32'd0);
      iwait = 0;

      // 5b: jump to self
      imem[8'h00] = enc_i(4'h7, 3'd0, 8'h00);
      reset_dut();
      for (int i = 0; i < 10; i++) step();
      check("t5_self_retire", 32'(n_retire), 32'd5);
      check("t5_self_addr", 32'(imem_addr), 32'h00);
      check("t5_self_halted", 32'(halted), 32'd0);

      // 5c: illegal opcode
      imem[8'h00] = 16'hF000;
      reset_dut();
      run_until_halt(20, c);
      check("t5_ill_cycles", 32'(c), 32'd2);
      check("t5_illegal", 32'(illegal), 32'd1);
      check("t5_ill_retire", 32'(n_retire), 32'd0);
      n_ireq = 0;
      for (int i = 0; i < 3; i++) step();
      check("t5_no_req", 32'(n_ireq), 32'd0);
      check("t5_halt_pc", 32'(imem_addr), 32'h00);

      // 6a: reset during a data wait, then a late ready
      clear_mem();
      imem[0] = enc_i(4'h1, 3'd1, 8'h11);
      imem[1] = enc_i(4'h1, 3'd2, 8'h40);
      imem[2] = enc_r(4'h5, 3'd3, 3'd2, 3'd0);
      dmem[8'h40] = 8'h77;
      dwait = 20;
      reset_dut();
      for (int i = 0; i < 6; i++) step();
      check("t6_in_mem", 32'(dmem_req), 32'd1);
      step();
      reset = 1'b1;
      step();
      check("t6_rst_dreq", 32'(dmem_req), 32'd0);
      check("t6_rst_ireq", 32'(imem_req), 32'd0);
      reset = 1'b0; force_dready = 1'b1; iwait = 20;
      step();
      force_dready = 1'b0;
      check("t6_late_dreq", 32'(dmem_req), 32'd0);
      check("t6_no_write", 32'(dut_a.regs_s[3]), 32'h00);
      check("t6_pc", 32'(imem_addr), 32'h00);
      check("t6_ireq", 32'(imem_req), 32'd1);
      dwait = 0; iwait = 0;

      // 6b: same sequence on the 16-bit data / 12-bit address instance
      step();
      reset_b = 1'b0; #1;
      check("b_rst_pc", 32'(b_imem_addr), 32'h0A5);
      check("b_ireq", 32'(b_imem_req), 32'd1);
      step(); step();
      check("b_sext", 32'(dut_b.regs_s[1]), 32'hFF80);
      step(); step();
      check("b_dreq", 32'(b_dmem_req), 32'd1);
      check("b_daddr", 32'(b_dmem_addr), 32'hF80);
      step();
      reset_b = 1'b1;
      step();
      check("b_rst_dreq", 32'(b_dmem_req), 32'd0);
      reset_b = 1'b0; b_dready = 1'b1;
      step();
      b_dready = 1'b0;
      check("b_late_dreq", 32'(b_dmem_req), 32'd0);
      check("b_no_write", 32'(dut_b.regs_s[3]), 32'h0000);
      check("b_pc", 32'(b_imem_addr), 32'h0A5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
